// File: rtl/hilo_reg_pkg.sv
// Shared definitions for the HI/LO register pair: data width and the
// active levels of reset and write enable.
package hilo_reg_pkg;

  localparam int unsigned RegDataWidth = 32;
  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteEnable  = 1'b1;

endpackage : hilo_reg_pkg

// File: rtl/hilo_reg_half.sv
// One half of the HI/LO pair: a DATA_WIDTH-wide register with write enable
// and synchronous reset; the output comes straight from the flop.
module hilo_half
  import hilo_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RegDataWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;

  // Only an explicit 1 loads; an unknown enable falls through to hold.
  always_comb begin
    data_d = data_q;
    if (we == WriteEnable) begin
      data_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule : hilo_half

// File: rtl/hilo_reg.sv
// HI/LO special-purpose register pair: two independent registers sharing
// clock and synchronous reset, each with its own write enable.
module hilo_reg
  import hilo_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RegDataWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_hi,
  input  logic [DATA_WIDTH-1:0] hi_data_in,
  input  logic                  we_lo,
  input  logic [DATA_WIDTH-1:0] lo_data_in,
  output logic [DATA_WIDTH-1:0] hi_data_out,
  output logic [DATA_WIDTH-1:0] lo_data_out
);

  hilo_half #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hi (
    .clk     (clk),
    .rst     (rst),
    .we      (we_hi),
    .data_in (hi_data_in),
    .data_out(hi_data_out)
  );

  hilo_half #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lo (
    .clk     (clk),
    .rst     (rst),
    .we      (we_lo),
    .data_in (lo_data_in),
    .data_out(lo_data_out)
  );

endmodule : hilo_reg

// File: tb/tb_hilo_reg.sv
// Self-checking bench for hilo_reg: directed cases followed by randomized
// traffic compared against a simple HI/LO value model.
module tb_hilo_reg;
  import hilo_reg_pkg::*;

  localparam int unsigned W = RegDataWidth;

  logic         clk = 1'b0;
  logic         rst;
  logic         we_hi;
  logic         we_lo;
  logic [W-1:0] hi_data_in;
  logic [W-1:0] lo_data_in;
  logic [W-1:0] hi_data_out;
  logic [W-1:0] lo_data_out;

  logic [W-1:0] hi_m;
  logic [W-1:0] lo_m;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  hilo_reg #(
    .DATA_WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we_hi      (we_hi),
    .hi_data_in (hi_data_in),
    .we_lo      (we_lo),
    .lo_data_in (lo_data_in),
    .hi_data_out(hi_data_out),
    .lo_data_out(lo_data_out)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_both(input string tag);
    check({tag, ".hi"}, hi_data_out, hi_m);
    check({tag, ".lo"}, lo_data_out, lo_m);
  endtask

  // Present inputs, let one rising edge sample them, update the model from
  // the same values, and return on the following falling edge.
  task automatic cycle(input logic r, input logic wh, input logic [W-1:0] hd,
                       input logic wl, input logic [W-1:0] ld);
    rst = r; we_hi = wh; hi_data_in = hd; we_lo = wl; lo_data_in = ld;
    @(posedge clk);
    if (r) begin
      hi_m = '0;
      lo_m = '0;
    end else begin
      if (wh) hi_m = hd;
      if (wl) lo_m = ld;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; we_hi = 1'b0; we_lo = 1'b0; hi_data_in = '0; lo_data_in = '0;
    hi_m = '0; lo_m = '0;
    @(negedge clk);

    // Reset wins over simultaneous writes of nonzero data.
    cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hCAFE_F00D);
    check("reset_prio.hi", hi_data_out, 32'h0);
    check("reset_prio.lo", lo_data_out, 32'h0);

    cycle(1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h1234_5678);
    check("hi_write.hi", hi_data_out, 32'h0000_0400);
    check("hi_write.lo", lo_data_out, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, $urandom(), 1'b0, $urandom());
      check_both("hi_hold");
    end

    cycle(1'b0, 1'b0, 32'h5555_5555, 1'b1, 32'h0010_0000);
    check("lo_write.lo", lo_data_out, 32'h0010_0000);
    check("lo_write.hi", hi_data_out, 32'h0000_0400);

    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hA5A5_A5A5);
    check("both_write.hi", hi_data_out, 32'hFFFF_FFFF);
    check("both_write.lo", lo_data_out, 32'hA5A5_A5A5);
    cycle(1'b0, 1'b0, 32'h0F0F_0F0F, 1'b0, 32'h1111_1111);
    check_both("both_hold");

    // Reset pulse entirely between edges must not disturb the registers.
    #1 rst = 1'b1;
    #2 check_both("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    check_both("mid_rst_after");

    // Enable and data pulse between edges, deasserted before the next edge.
    #1 we_hi = 1'b1; we_lo = 1'b1; hi_data_in = 32'h1357_9BDF; lo_data_in = 32'h2468_ACE0;
    #2 check_both("mid_we");
    we_hi = 1'b0; we_lo = 1'b0;
    cycle(1'b0, 1'b0, 32'h1357_9BDF, 1'b0, 32'h2468_ACE0);
    check_both("mid_we_after");

    // Reset raised mid-period and held across an edge.
    #1 rst = 1'b1;
    #2 check_both("edge_rst_pre");
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("edge_rst.hi", hi_data_out, 32'h0);
    check("edge_rst.lo", lo_data_out, 32'h0);

    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(15) == 0), $urandom_range(1), $urandom(),
            $urandom_range(1), $urandom());
      check_both("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hilo_reg
